// File: rtl/shared_counter_arbiter.sv
// shared_counter_arbiter
//   One WIDTH-bit up/down/load counter shared by REQUESTERS clients.
//   A round-robin arbiter picks one pending client in IDLE, and a
//   three-state sequencer (IDLE -> GRANT -> ACK -> IDLE) applies that
//   client's operation.  At most one operation completes every 3 cycles.
//
// Ports
//   clock      : single clock, all state updates on posedge
//   reset_     : synchronous, active-high reset
//   req        : per-client request, bit i = client i
//   op         : per-client opcode, bits [2i+1:2i]; 0=NOP 1=INC 2=DEC 3=LOAD
//   data       : per-client load value, bits [WIDTH*i +: WIDTH]
//   grant      : one-hot client being serviced (GRANT and ACK cycles)
//   ack        : one-hot single-cycle pulse, the client's op has been applied
//   out        : current counter value
//   busy       : high whenever the sequencer is not IDLE
//   dbg_state  : raw sequencer state (0=IDLE 1=GRANT 2=ACK)
//
// Handshake: a client raises req with op/data and holds all three stable
// until it sees its ack bit; req is only sampled in IDLE, so dropping it
// after the grant has been latched does not cancel the operation.
//
// Optional feature (macro SHARED_COUNTER_SATURATE_EN): when defined, INC
// saturates at all-ones and DEC saturates at zero instead of wrapping.

module shared_counter_arbiter #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4
) (
  input  logic                        clock,
  input  logic                        reset_,
  input  logic [REQUESTERS-1:0]       req,
  input  logic [2*REQUESTERS-1:0]     op,
  input  logic [WIDTH*REQUESTERS-1:0] data,
  output logic [REQUESTERS-1:0]       grant,
  output logic [REQUESTERS-1:0]       ack,
  output logic [WIDTH-1:0]            out,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  localparam logic [REQUESTERS-1:0] ONE_HOT0 = REQUESTERS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   lat_id;
  logic [1:0]      lat_op;
  logic [WIDTH-1:0] lat_data;

  // Arbitration result for the current IDLE cycle
  logic            win_found;
  logic [PW-1:0]   win_id;
  logic [1:0]      win_op;
  logic [WIDTH-1:0] win_data;
  logic [PW-1:0]   ptr_next;

  logic [WIDTH-1:0] cnt_next;

  // Round-robin search: walk upward from ptr, wrapping at REQUESTERS-1.
  // The candidate index is wrapped by subtraction so non-power-of-two
  // client counts work without a modulo operator.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    win_op    = OP_NOP;
    win_data  = '0;
    idx       = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = PW'(idx);
        win_op    = op[2*idx +: 2];
        win_data  = data[WIDTH*idx +: WIDTH];
      end
    end
  end

  always_comb begin
    if (win_id == PW'(REQUESTERS-1)) ptr_next = '0;
    else                             ptr_next = win_id + PW'(1);
  end

  // Counter update applied at the GRANT -> ACK edge
  always_comb begin
    cnt_next = out;
    case (lat_op)
      OP_INC: begin
`ifdef SHARED_COUNTER_SATURATE_EN
        if (out != '1) cnt_next = out + WIDTH'(1);
`else
        cnt_next = out + WIDTH'(1);
`endif
      end
      OP_DEC: begin
`ifdef SHARED_COUNTER_SATURATE_EN
        if (out != '0) cnt_next = out - WIDTH'(1);
`else
        cnt_next = out - WIDTH'(1);
`endif
      end
      OP_LOAD: cnt_next = lat_data;
      default: cnt_next = out;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      state    <= IDLE;
      ptr      <= '0;
      lat_id   <= '0;
      lat_op   <= OP_NOP;
      lat_data <= '0;
      grant    <= '0;
      ack      <= '0;
      out      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            lat_id   <= win_id;
            lat_op   <= win_op;
            lat_data <= win_data;
            grant    <= ONE_HOT0 << win_id;
            ptr      <= ptr_next;
            state    <= GRANT;
          end
        end
        GRANT: begin
          out   <= cnt_next;
          ack   <= ONE_HOT0 << lat_id;
          state <= ACK;
        end
        ACK: begin
          ack   <= '0;
          grant <= '0;
          state <= IDLE;
        end
        default: begin
          ack   <= '0;
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Self-checking bench for shared_counter_arbiter (WIDTH=16, REQUESTERS=4).
// Expected {ack, out} pairs are queued when a request is driven and are
// popped by a monitor whenever the DUT pulses ack.  Cycle-exact checks of
// grant/busy timing are made by the driver tasks themselves.

module tb_shared_counter_arbiter;

  localparam int W  = 16;
  localparam int R  = 4;
  localparam int EW = R + W;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  logic           clock;
  logic           reset_;
  logic [R-1:0]   req;
  logic [2*R-1:0] op;
  logic [W*R-1:0] data;
  logic [R-1:0]   grant;
  logic [R-1:0]   ack;
  logic [W-1:0]   out;
  logic           busy;
  logic [1:0]     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  model;

  shared_counter_arbiter #(.WIDTH(W), .REQUESTERS(R)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .req       (req),
    .op        (op),
    .data      (data),
    .grant     (grant),
    .ack       (ack),
    .out       (out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] model_op(input logic [W-1:0] cur, input logic [1:0] o,
                                            input logic [W-1:0] d);
    logic [W-1:0] nxt;
    nxt = cur;
    case (o)
`ifdef SHARED_COUNTER_SATURATE_EN
      OP_INC:  nxt = (cur == 16'hFFFF) ? cur : cur + 16'd1;
      OP_DEC:  nxt = (cur == 16'h0000) ? cur : cur - 16'd1;
`else
      OP_INC:  nxt = cur + 16'd1;
      OP_DEC:  nxt = cur - 16'd1;
`endif
      OP_LOAD: nxt = d;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic [R-1:0] onehot(input int c);
    logic [R-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Scoreboard: every ack pulse must match the head of exp_q
  always @(negedge clock) begin
    if (!reset_ && ack != '0) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check_val("ack_id", 32'(ack), 32'(e[EW-1:W]));
        check_val("ack_out", 32'(out), 32'(e[W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset_ = 1'b1;
    req    = '0;
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b0;
    model  = '0;
  endtask

  task automatic drive_client(input int c, input logic [1:0] o, input logic [W-1:0] d);
    req[c]        = 1'b1;
    op[2*c +: 2]  = o;
    data[W*c +: W] = d;
    model = model_op(model, o, d);
    exp_q.push_back({onehot(c), model});
  endtask

  // Single request from an idle DUT with no competing clients.
  task automatic issue_single(input int c, input logic [1:0] o, input logic [W-1:0] d,
                              input bit drop_early);
    @(negedge clock);
    drive_client(c, o, d);
    @(negedge clock);
    check_val("grant_cycle1", 32'(grant), 32'(onehot(c)));
    check_val("busy_cycle1", 32'(busy), 32'd1);
    if (drop_early) req[c] = 1'b0;
    @(negedge clock);
    check_val("grant_in_ack", 32'(grant), 32'(onehot(c)));
    req[c] = 1'b0;
    @(negedge clock);
    check_val("busy_cycle3", 32'(busy), 32'd0);
    check_val("grant_idle", 32'(grant), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_ = 1'b1;
    req    = '0;
    op     = '0;
    data   = '0;
    model  = '0;

    // Reset state
    do_reset();
    check_val("rst_out", 32'(out), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);

    // Client 0 LOAD 0x1234
    issue_single(0, OP_LOAD, 16'h1234, 1'b0);
    check_val("load_out", 32'(out), 32'h1234);

    // Fairness: all clients INC continuously from 0
    do_reset();
    @(negedge clock);
    for (int c = 0; c < R; c++) begin
      req[c]       = 1'b1;
      op[2*c +: 2] = OP_INC;
    end
    for (int k = 0; k < 5; k++) begin
      model = model_op(model, OP_INC, '0);
      exp_q.push_back({onehot(k % R), model});
    end
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      check_val("rr_ack_slot", 32'(ack != '0), 32'(i % 3 == 2));
    end
    req = '0;
    @(negedge clock);
    check_val("rr_idle", 32'(busy), 32'd0);
    check_val("rr_out", 32'(out), 32'd5);

    // Wrap (or saturate) at both ends, client 2
    issue_single(2, OP_LOAD, 16'hFFFF, 1'b0);
    issue_single(2, OP_INC, 16'h0000, 1'b0);
    issue_single(2, OP_DEC, 16'h0000, 1'b0);
    issue_single(2, OP_LOAD, 16'h0000, 1'b0);
    issue_single(2, OP_DEC, 16'h0000, 1'b0);
    issue_single(2, OP_INC, 16'h0000, 1'b0);

    // Withdrawal during GRANT still completes the op exactly once
    issue_single(0, OP_LOAD, 16'h0005, 1'b0);
    issue_single(0, OP_DEC, 16'h0000, 1'b1);
    check_val("withdraw_out", 32'(out), 32'd4);
    @(negedge clock);
    check_val("no_second_op", 32'(busy), 32'd0);

    // Reset during GRANT drops the op
    @(negedge clock);
    req[1]       = 1'b1;
    op[3:2]      = OP_LOAD;
    data[31:16]  = 16'h00AA;
    @(negedge clock);
    check_val("pre_rst_grant", 32'(grant), 32'(onehot(1)));
    reset_ = 1'b1;
    req    = '0;
    @(negedge clock);
    reset_ = 1'b0;
    model  = '0;
    check_val("midrst_out", 32'(out), 32'd0);
    check_val("midrst_grant", 32'(grant), 32'd0);
    check_val("midrst_ack", 32'(ack), 32'd0);
    check_val("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    check_val("midrst_no_ack", 32'(ack), 32'd0);
    issue_single(3, OP_LOAD, 16'h0033, 1'b0);

    // Pointer to 2 via client 1, then clients 1 and 3 together
    issue_single(1, OP_LOAD, 16'h0042, 1'b0);
    @(negedge clock);
    drive_client(3, OP_INC, 16'h0000);
    drive_client(1, OP_NOP, 16'h0000);
    @(negedge clock);
    check_val("sim_grant_first", 32'(grant), 32'(onehot(3)));
    @(negedge clock);
    req[3] = 1'b0;
    @(negedge clock);
    check_val("sim_idle_gap", 32'(grant), 32'd0);
    @(negedge clock);
    check_val("sim_grant_second", 32'(grant), 32'(onehot(1)));
    @(negedge clock);
    req[1] = 1'b0;
    @(negedge clock);
    check_val("sim_done_busy", 32'(busy), 32'd0);
    check_val("nop_out", 32'(out), 32'h0043);

    @(negedge clock);
    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
